fifo_core: RTL and testbench
============================

# fifo_core

Synchronous first-in/first-out buffer implementing the storage end of the FIFO push/pop interface. It accepts words on `push`/`data_in` when write-enabled and returns them in order on `pop`/`data_out` under output-enable control. It reports `full` and `empty` status. This is the block driven and monitored by the FIFO UVC.

## Interface
- `DATAWIDTH`, default 8: word width in bits.
- `DEPTH`, default 16: number of entries; must be a power of two and at least 2.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `reset`  input  1: asynchronous, active-high reset.
- `push`  input  1: write request.
- `wr_en`  input  1: write enable; a `push` is ignored unless `wr_en`=1.
- `data_in`  input  DATAWIDTH: write data, sampled with an accepted push.
- `pop`  input  1: read request.
- `oe`  input  1: output enable for `data_out`.
- `data_out`  output  DATAWIDTH: read data register, gated by `oe`.
- `full`  output  1: occupancy equals DEPTH.
- `empty`  output  1: occupancy equals 0.

## Operation
- State: storage array[DEPTH], write pointer `wptr`, read pointer `rptr`, occupancy `count`, output register `dout_q`.
- `wptr` and `rptr` are $clog2(DEPTH) bits. `count` is $clog2(DEPTH)+1 bits.
- Accepted write: `wr_acc = push & wr_en & ~full`.
  - Store `data_in` at `wptr`.
  - `wptr` increments modulo DEPTH, wrapping naturally from DEPTH-1 to 0.
- Accepted read: `rd_acc = pop & ~empty`.
  - `dout_q` loads array[`rptr`].
  - `rptr` increments modulo DEPTH.
- Count update:
  - `count` +1 on `wr_acc` only.
  - `count` -1 on `rd_acc` only.
  - `count` unchanged when both or neither are accepted.
- `full` = (`count`==DEPTH); `empty` = (`count`==0). Both are decoded from registered `count`, so they reflect state at the start of the cycle.
- Boundary rules:
  - Push while `full`: dropped, even if `pop` is in the same cycle. No pointer or data change; `count` decrements if the pop is accepted.
  - Pop while `empty`: ignored, even if `push` is in the same cycle. `dout_q` holds and `rptr` is unchanged; the push is accepted.
  - Push and pop both accepted: both pointers advance and `count` holds. The read returns the old head, never the word being written.
  - `wr_en`=0 with `push`=1: no write, no error.
- `dout_q` holds its value between accepted reads.
- `data_out` = `oe` ? `dout_q` : 0. This path is combinational; `oe` affects visibility only, not FIFO state.
- Reset (asserted at any time, including mid-burst):
  - `wptr`, `rptr`, `count` and `dout_q` clear to 0.
  - `full`=0, `empty`=1, `data_out`=0.
  - Storage contents are not cleared and are unobservable until rewritten.

## Timing
- Write latency: a word pushed at edge N is poppable from edge N+1. `empty` deasserts after edge N.
- Read latency: 1 cycle. A pop accepted at edge N presents the word on `dout_q` after edge N, for `oe`=1.
- `full` and `empty` update in the same cycle as `count`; no lookahead.
- Reset assertion takes effect immediately. Deassertion is synchronized by the integrator; the first accepted operation is at the first edge after reset is low.

## Configuration
- Macro: `FIFO_CORE_ERR_FLAG_EN`.
- Defined: adds two outputs.
  - `overflow` (output, 1): a registered one-cycle pulse, the cycle after `push & wr_en & full`.
  - `underflow` (output, 1): a registered one-cycle pulse, the cycle after `pop & empty`.
  - Both reset to 0.
- Undefined: these ports and their logic are absent. Dropped pushes and ignored pops are silent; all other behaviour is identical.

## Test plan
- Reset, then idle: `empty`=1, `full`=0, `data_out`=0. Assert `reset` mid-burst after 5 pushes: `empty`=1 immediately, and the next pop (`oe`=1) leaves `data_out`=0.
- Push 0x01..0x10 with `wr_en`=1 (DEPTH=16): `full`=1 after the 16th edge. A 17th push of 0xAA is dropped, and `overflow` pulses when enabled. Then pop 16 times with `oe`=1: `data_out` reads 0x01..0x10 in order, and `empty`=1 after the last pop.
- Wrap-around: push 12 words, pop 12, push 10 (0x20..0x29), pop 10. Expect 0x20..0x29 in order, with no `full`/`empty` glitches.
- Simultaneous push and pop with `count`=3: `count` stays 3 and `data_out`=the old head. At `full`, push+pop: pop returns the head, push is dropped, and `full` deasserts. At `empty`, push+pop: push is accepted, `data_out` is unchanged, and `empty` deasserts.
- `push`=1 with `wr_en`=0 for 4 cycles: `empty` stays 1. A pop at `empty` holds `dout_q`, and `underflow` pulses when enabled.
- `oe` toggle: after popping 0x5A, `oe`=0 gives `data_out`=0 and `oe`=1 gives 0x5A again, with no pointer movement.

Source files
------------

// File: rtl/fifo_core_if.sv
// fifo_core_if -- push/pop bus between a FIFO client and fifo_core.
//   master : client side (drives push, wr_en, data_in, pop, oe)
//   slave  : fifo_core side (drives data_out, full, empty)
// With FIFO_CORE_ERR_FLAG_EN defined the bus also carries the
// overflow/underflow pulses (driven by the slave).
interface fifo_core_if #(
  parameter int DATAWIDTH = 8
);
  logic                 push;
  logic                 wr_en;
  logic [DATAWIDTH-1:0] data_in;
  logic                 pop;
  logic                 oe;
  logic [DATAWIDTH-1:0] data_out;
  logic                 full;
  logic                 empty;
`ifdef FIFO_CORE_ERR_FLAG_EN
  logic                 overflow;
  logic                 underflow;

  modport master (
    output push, wr_en, data_in, pop, oe,
    input  data_out, full, empty, overflow, underflow
  );
  modport slave (
    input  push, wr_en, data_in, pop, oe,
    output data_out, full, empty, overflow, underflow
  );
`else
  modport master (
    output push, wr_en, data_in, pop, oe,
    input  data_out, full, empty
  );
  modport slave (
    input  push, wr_en, data_in, pop, oe,
    output data_out, full, empty
  );
`endif
endinterface

// File: rtl/fifo_core.sv
// fifo_core -- synchronous FIFO, storage end of the push/pop interface.
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : fifo_core_if.slave
//            push/wr_en/data_in : write request, enable, data
//            pop/oe             : read request, output enable
//            data_out           : read register, forced to 0 when oe=0
//            full/empty         : decoded from registered occupancy
// Optional feature macro FIFO_CORE_ERR_FLAG_EN: adds registered
// overflow (push & wr_en & full) and underflow (pop & empty) pulses.
module fifo_core #(
  parameter int DATAWIDTH = 8,
  parameter int DEPTH     = 16
) (
  input  logic          clk,
  input  logic          reset,
  fifo_core_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATAWIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]        r_wptr, r_rptr;
  logic [AW:0]          r_count;
  logic [DATAWIDTH-1:0] r_dout;

  logic w_full, w_empty, w_wr_acc, w_rd_acc;

  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  // Flags come from the start-of-cycle count, so a pop never frees room
  // for a same-cycle push and a push never feeds a same-cycle pop.
  assign w_wr_acc = bus.push & bus.wr_en & ~w_full;
  assign w_rd_acc = bus.pop & ~w_empty;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wptr] <= bus.data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_dout  <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_rd_acc) begin
        r_dout <= r_mem[r_rptr];
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.data_out = bus.oe ? r_dout : '0;
  assign bus.full     = w_full;
  assign bus.empty    = w_empty;

`ifdef FIFO_CORE_ERR_FLAG_EN
  logic r_overflow, r_underflow;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= bus.push & bus.wr_en & w_full;
      r_underflow <= bus.pop & w_empty;
    end
  end
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
`endif
endmodule

// File: tb/tb_fifo_core.sv
module tb_fifo_core;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_core_if #(.DATAWIDTH(DW)) bus ();
  fifo_core #(.DATAWIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] sb[$];     // expected words in FIFO order
  logic [DW-1:0] m_dout;    // expected read register
  int            m_cnt;     // expected occupancy

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; inputs applied #1 after a rising edge, outputs
  // checked #1 after the next rising edge.
  task automatic op(input string tag, input logic ps, input logic we,
                    input logic [DW-1:0] d, input logic pp, input logic oe_i);
    logic wacc, racc, was_full, was_empty;
    was_full  = (m_cnt == DEPTH);
    was_empty = (m_cnt == 0);
    wacc = ps & we & ~was_full;
    racc = pp & ~was_empty;
    bus.push = ps; bus.wr_en = we; bus.data_in = d; bus.pop = pp; bus.oe = oe_i;
    @(posedge clk); #1;
    if (racc) m_dout = sb.pop_front();
    if (wacc) sb.push_back(d);
    m_cnt = m_cnt + (wacc ? 1 : 0) - (racc ? 1 : 0);
    chk({tag, "/dout"},  32'(bus.data_out), 32'(oe_i ? m_dout : '0));
    chk({tag, "/full"},  32'(bus.full),     32'(m_cnt == DEPTH));
    chk({tag, "/empty"}, 32'(bus.empty),    32'(m_cnt == 0));
`ifdef FIFO_CORE_ERR_FLAG_EN
    chk({tag, "/ovf"},   32'(bus.overflow),  32'(ps & we & was_full));
    chk({tag, "/unf"},   32'(bus.underflow), 32'(pp & was_empty));
`endif
    bus.push = 1'b0; bus.pop = 1'b0;
  endtask

  task automatic push_n(input string tag, input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) op(tag, 1'b1, 1'b1, base + DW'(i), 1'b0, 1'b1);
  endtask

  task automatic pop_n(input string tag, input int n);
    for (int i = 0; i < n; i++) op(tag, 1'b0, 1'b0, '0, 1'b1, 1'b1);
  endtask

  task automatic model_reset();
    sb.delete();
    m_cnt  = 0;
    m_dout = '0;
  endtask

  initial begin
    bus.push = 1'b0; bus.wr_en = 1'b0; bus.data_in = '0; bus.pop = 1'b0; bus.oe = 1'b1;
    model_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst/empty", 32'(bus.empty), 32'd1);
    chk("rst/full",  32'(bus.full),  32'd0);
    chk("rst/dout",  32'(bus.data_out), 32'd0);
    reset = 1'b0;
    op("idle", 1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Reset mid-burst: takes effect without waiting for an edge.
    push_n("burst", 5, 8'h61);
    op("burst_pop", 1'b0, 1'b0, '0, 1'b1, 1'b1);   // dout_q now nonzero
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("midrst/empty", 32'(bus.empty), 32'd1);
    chk("midrst/dout",  32'(bus.data_out), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    op("postrst_pop", 1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Fill, overflow, drain.
    push_n("fill", DEPTH, 8'h01);
    op("drop_aa", 1'b1, 1'b1, 8'hAA, 1'b0, 1'b1);
    pop_n("drain", DEPTH);

    // Wrap-around of both pointers.
    push_n("wrap_a", 12, 8'h40);
    pop_n("wrap_a", 12);
    push_n("wrap_b", 10, 8'h20);
    pop_n("wrap_b", 10);

    // Simultaneous push+pop at count=3, at full, at empty.
    push_n("mid", 3, 8'h70);
    op("mid_pp", 1'b1, 1'b1, 8'h90, 1'b1, 1'b1);
    push_n("tofull", DEPTH - 3, 8'hB0);
    op("full_pp", 1'b1, 1'b1, 8'hEE, 1'b1, 1'b1);
    pop_n("drain2", DEPTH - 1);
    op("empty_pp", 1'b1, 1'b1, 8'hC3, 1'b1, 1'b1);
    pop_n("drain3", 1);

    // push without wr_en, then pop at empty.
    for (int i = 0; i < 4; i++) op("no_wren", 1'b1, 1'b0, 8'h33, 1'b0, 1'b1);
    op("pop_empty", 1'b0, 1'b0, '0, 1'b1, 1'b1);
    op("after_unf", 1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Output-enable gating only.
    push_n("oe", 1, 8'h5A);
    pop_n("oe", 1);
    op("oe_off", 1'b0, 1'b0, '0, 1'b0, 1'b0);
    op("oe_on",  1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Random mix against the scoreboard.
    for (int i = 0; i < 200; i++)
      op("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
         DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
